// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - sequential shift-add multiply / restoring divide unit feeding HI/LO
// Optional feature macro: MULDIV_UNSIGNED_EN (op[1]=1 selects unsigned operation).
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DZ} stateT;

  stateT            state, nextState;
  logic [CNT_W-1:0] count;
  logic             isDiv, negLo, negHi;
  logic [WIDTH-1:0] divisor, workHi, workLo;

  logic             isSigned, aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH:0]   mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0] product, productFix;

`ifdef MULDIV_UNSIGNED_EN
  assign isSigned = ~op[1];
`else
  // op[1] is a don't-care in signed-only builds; the OR folds to constant 1
  assign isSigned = op[1] | 1'b1;
`endif

  assign aNeg = isSigned & a[WIDTH-1];
  assign bNeg = isSigned & b[WIDTH-1];
  assign aMag = aNeg ? -a : a;
  assign bMag = bNeg ? -b : b;

  // workHi/workLo double as accumulator/multiplier or remainder/quotient
  always_comb begin
    mulSum     = {1'b0, workHi} + (workLo[0] ? {1'b0, divisor} : '0);
    divShift   = {workHi, workLo[WIDTH-1]};
    divDiff    = divShift - {1'b0, divisor};
    product    = {workHi, workLo};
    productFix = negLo ? -product : product;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = (op[0] && b == '0) ? DZ : RUN;
      RUN:     if (count == CNT_W'(1)) nextState = FIX;
      FIX:     nextState = IDLE;
      DZ:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      isDiv    <= 1'b0;
      negLo    <= 1'b0;
      negHi    <= 1'b0;
      divisor  <= '0;
      workHi   <= '0;
      workLo   <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isDiv    <= op[0];
            negLo    <= aNeg ^ bNeg;
            negHi    <= aNeg;
            divisor  <= bMag;
            workHi   <= '0;
            workLo   <= aMag;
            count    <= CNT_W'(WIDTH);
            div_zero <= 1'b0;
          end
        end
        RUN: begin
          count <= count - CNT_W'(1);
          if (isDiv) begin
            // restoring step: keep the trial difference only when it did not borrow
            if (!divDiff[WIDTH]) begin
              workHi <= divDiff[WIDTH-1:0];
              workLo <= {workLo[WIDTH-2:0], 1'b1};
            end else begin
              workHi <= divShift[WIDTH-1:0];
              workLo <= {workLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            workHi <= mulSum[WIDTH:1];
            workLo <= {mulSum[0], workLo[WIDTH-1:1]};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (isDiv) begin
            hi <= negHi ? -workHi : workHi;
            lo <= negLo ? -workLo : workLo;
          end else begin
            {hi, lo} <= productFix;
          end
        end
        DZ: begin
          done     <= 1'b1;
          div_zero <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
